// File: rtl/xy_switch_alloc.sv
// Switch allocator: per-output round-robin arbitration feeding a 1-flit output register per port.
// Latency: 1 cycle from input handshake (in_vld_i & in_rdy_o) to out_vld_o.
// Backpressure: a full output slot (vld=1, rdy=0) grants nobody; its requesters see in_rdy_o=0 and hold.
module xy_switch_alloc #(
  parameter int PORT_N     = 5,
  parameter int OUTPUT_N_W = 3,
  parameter int DATA_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [PORT_N-1:0]            in_vld_i,
  input  logic [PORT_N*OUTPUT_N_W-1:0] in_sel_i,
  input  logic [PORT_N*DATA_W-1:0]     in_data_i,
  output logic [PORT_N-1:0]            in_rdy_o,
  input  logic [PORT_N-1:0]            out_rdy_i,
  output logic [PORT_N-1:0]            out_vld_o,
  output logic [PORT_N*DATA_W-1:0]     out_data_o,
  output logic                         err_o
);

  typedef logic [OUTPUT_N_W-1:0] idx_t;
  typedef logic [OUTPUT_N_W:0]   idx_ext_t;

  localparam idx_ext_t PORT_N_L = idx_ext_t'(PORT_N);

  idx_t              sel     [PORT_N];
  logic [DATA_W-1:0] data_in [PORT_N];
  logic [PORT_N-1:0] oob;

  logic [PORT_N-1:0] slot_free;
  logic [PORT_N-1:0] gnt_vld;
  logic [PORT_N-1:0] in_gnt;
  idx_t              gnt_idx [PORT_N];
  idx_ext_t          scan;
  idx_t              cand;

  logic [PORT_N-1:0] out_vld_d, out_vld_q;
  logic [DATA_W-1:0] out_data_d [PORT_N];
  logic [DATA_W-1:0] out_data_q [PORT_N];
  idx_t              ptr_d [PORT_N];
  idx_t              ptr_q [PORT_N];
  logic              err_d, err_q;
  idx_ext_t          nxt;

  // Unpack the flat input buses and flag requests that name a nonexistent output.
  always_comb begin
    sel     = '{default: '0};
    data_in = '{default: '0};
    oob     = '0;
    for (int i = 0; i < PORT_N; i++) begin
      sel[i]     = in_sel_i[i*OUTPUT_N_W +: OUTPUT_N_W];
      data_in[i] = in_data_i[i*DATA_W +: DATA_W];
      oob[i]     = in_vld_i[i] && ({1'b0, sel[i]} >= PORT_N_L);
    end
  end

  // Per free output, scan inputs starting at its pointer; the first requester wins.
  always_comb begin
    slot_free = '0;
    gnt_vld   = '0;
    in_gnt    = '0;
    gnt_idx   = '{default: '0};
    scan      = '0;
    cand      = '0;
    for (int o = 0; o < PORT_N; o++) begin
      slot_free[o] = !out_vld_q[o] || out_rdy_i[o];
      for (int k = 0; k < PORT_N; k++) begin
        scan = {1'b0, ptr_q[o]} + idx_ext_t'(k);
        if (scan >= PORT_N_L) scan = scan - PORT_N_L;
        cand = scan[OUTPUT_N_W-1:0];
        if (slot_free[o] && !gnt_vld[o] && in_vld_i[cand] && (sel[cand] == idx_t'(o))) begin
          gnt_vld[o]   = 1'b1;
          gnt_idx[o]   = cand;
          in_gnt[cand] = 1'b1;
        end
      end
    end
  end

  // Out-of-range flits are swallowed immediately; nothing is accepted while in reset.
  assign in_rdy_o = rst_ni ? (in_vld_i & (in_gnt | oob)) : '0;

  // Next state: load winners, drain consumed slots, advance pointers past the winner.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    ptr_d      = ptr_q;
    err_d      = err_q | (|oob);
    nxt        = '0;
    for (int o = 0; o < PORT_N; o++) begin
      if (slot_free[o]) begin
        out_vld_d[o] = gnt_vld[o];
        if (gnt_vld[o]) begin
          out_data_d[o] = data_in[gnt_idx[o]];
          nxt = {1'b0, gnt_idx[o]} + idx_ext_t'(1);
          if (nxt >= PORT_N_L) nxt = '0;
          ptr_d[o] = nxt[OUTPUT_N_W-1:0];
        end
      end
    end
  end

  // State registers with synchronous active-low reset; held flits are discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_vld_q  <= '0;
      out_data_q <= '{default: '0};
      ptr_q      <= '{default: '0};
      err_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
    end
  end

  for (genvar g = 0; g < PORT_N; g++) begin : g_out
    assign out_data_o[g*DATA_W +: DATA_W] = out_data_q[g];
  end

  assign out_vld_o = out_vld_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_xy_switch_alloc.sv
// Bench for xy_switch_alloc: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: outputs sampled 1 time unit after each rising edge, in_rdy sampled mid-cycle.
// Backpressure: out_rdy driven directly by the bench, randomized in the random phase.
module tb_xy_switch_alloc;
  localparam int N = 5;
  localparam int W = 3;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_vld, in_rdy, out_rdy, out_vld;
  logic [N*W-1:0] in_sel;
  logic [N*D-1:0] in_data, out_data;
  logic           err;

  always #5 clk = ~clk;

  xy_switch_alloc #(.PORT_N(N), .OUTPUT_N_W(W), .DATA_W(D)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_vld_i(in_vld), .in_sel_i(in_sel), .in_data_i(in_data), .in_rdy_o(in_rdy),
    .out_rdy_i(out_rdy), .out_vld_o(out_vld), .out_data_o(out_data), .err_o(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: each output is a one-entry slot with a "next favoured input" pointer.
  bit         m_vld  [N];
  logic [7:0] m_data [N];
  int         m_ptr  [N];
  bit         m_err;
  int         m_win  [N];
  logic [N-1:0] exp_rdy;

  function automatic int sel_of(int i);
    return int'(in_sel[i*W +: W]);
  endfunction

  function automatic logic [7:0] din_of(int i);
    return in_data[i*D +: D];
  endfunction

  function automatic logic [7:0] dout_of(int o);
    return out_data[o*D +: D];
  endfunction

  function automatic logic [N-1:0] m_vld_vec();
    logic [N-1:0] v;
    for (int o = 0; o < N; o++) v[o] = m_vld[o];
    return v;
  endfunction

  // Winner = requester at the smallest round-robin distance from the pointer.
  function automatic void model_comb();
    int best, bestd, d;
    exp_rdy = '0;
    for (int o = 0; o < N; o++) m_win[o] = -1;
    if (rst_n !== 1'b1) return;
    for (int i = 0; i < N; i++)
      if (in_vld[i] && sel_of(i) >= N) exp_rdy[i] = 1'b1;
    for (int o = 0; o < N; o++) begin
      if (!m_vld[o] || out_rdy[o]) begin
        best = -1; bestd = N;
        for (int i = 0; i < N; i++) begin
          if (in_vld[i] && sel_of(i) == o) begin
            d = (i - m_ptr[o] + N) % N;
            if (d < bestd) begin best = i; bestd = d; end
          end
        end
        m_win[o] = best;
        if (best >= 0) exp_rdy[best] = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge();
    if (rst_n !== 1'b1) begin
      for (int o = 0; o < N; o++) begin m_vld[o] = 0; m_data[o] = '0; m_ptr[o] = 0; end
      m_err = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (in_vld[i] && sel_of(i) >= N) m_err = 1;
    for (int o = 0; o < N; o++) begin
      if (!m_vld[o] || out_rdy[o]) begin
        if (m_win[o] >= 0) begin
          m_vld[o]  = 1;
          m_data[o] = din_of(m_win[o]);
          m_ptr[o]  = (m_win[o] + 1) % N;
        end else begin
          m_vld[o] = 0;
        end
      end
    end
  endfunction

  task automatic set_in(input int i, input bit v, input int s, input logic [7:0] d);
    in_vld[i]        = v;
    in_sel[i*W +: W] = s[W-1:0];
    in_data[i*D +: D] = d;
  endtask

  task automatic clear_in();
    in_vld = '0; in_sel = '0; in_data = '0;
  endtask

  task automatic advance();
    model_comb();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear_in(); out_rdy = '1;
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_rdy = '1;
    for (int i = 0; i < N; i++) set_in(i, 1'b1, 0, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (in_rdy !== '0) begin n_fail++; $display("FAIL reset_in_rdy: got %b expected 0", in_rdy); end
      advance();
      n_tests++;
      if (out_vld !== '0 || err !== 1'b0 || out_data !== '0) begin
        n_fail++; $display("FAIL reset_state: out_vld=%b err=%b out_data=%h expected all 0", out_vld, err, out_data);
      end
    end
    rst_n = 1'b1; clear_in();
  endtask

  task automatic test_single();
    do_reset();
    set_in(1, 1'b1, 3, 8'hA5);
    #1;
    n_tests++;
    if (in_rdy !== 5'b00010) begin n_fail++; $display("FAIL single_rdy: got %b expected 00010", in_rdy); end
    advance();
    clear_in();
    n_tests++;
    if (out_vld !== 5'b01000 || dout_of(3) !== 8'hA5) begin
      n_fail++; $display("FAIL single_out: vld=%b data=%h expected 01000/a5", out_vld, dout_of(3));
    end
    advance();
    n_tests++;
    if (out_vld !== '0) begin n_fail++; $display("FAIL single_drain: vld=%b expected 0", out_vld); end
  endtask

  task automatic test_contention();
    int order [6] = '{0, 2, 4, 0, 2, 4};
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < N; i += 2) set_in(i, 1'b1, 0, 8'(8'h40 + i));
    for (int c = 0; c < 6; c++) begin
      #1;
      want = N'(1) << order[c];
      n_tests++;
      if (in_rdy !== want) begin n_fail++; $display("FAIL contention_rdy[%0d]: got %b expected %b", c, in_rdy, want); end
      advance();
      n_tests++;
      if (out_vld[0] !== 1'b1 || dout_of(0) !== 8'(8'h40 + order[c])) begin
        n_fail++; $display("FAIL contention_out[%0d]: vld=%b data=%h expected 1/%h", c, out_vld[0], dout_of(0), 8'(8'h40 + order[c]));
      end
    end
    clear_in();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy[2] = 1'b0;
    set_in(1, 1'b1, 2, 8'h11);
    #1;
    n_tests++;
    if (in_rdy[1] !== 1'b1) begin n_fail++; $display("FAIL bp_first_rdy: got %b expected 1", in_rdy[1]); end
    advance();
    set_in(1, 1'b1, 2, 8'h22);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (in_rdy[1] !== 1'b0) begin n_fail++; $display("FAIL bp_stall_rdy: got %b expected 0", in_rdy[1]); end
      advance();
      n_tests++;
      if (out_vld[2] !== 1'b1 || dout_of(2) !== 8'h11) begin
        n_fail++; $display("FAIL bp_hold: vld=%b data=%h expected 1/11", out_vld[2], dout_of(2));
      end
    end
    out_rdy[2] = 1'b1;
    #1;
    n_tests++;
    if (in_rdy[1] !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b expected 1", in_rdy[1]); end
    advance();
    clear_in();
    n_tests++;
    if (out_vld[2] !== 1'b1 || dout_of(2) !== 8'h22) begin
      n_fail++; $display("FAIL bp_b2b: vld=%b data=%h expected 1/22", out_vld[2], dout_of(2));
    end
    advance();
    n_tests++;
    if (out_vld[2] !== 1'b0 || dout_of(2) !== 8'h22) begin
      n_fail++; $display("FAIL bp_drain: vld=%b data=%h expected 0/22", out_vld[2], dout_of(2));
    end
  endtask

  task automatic test_invalid_sel();
    do_reset();
    set_in(3, 1'b1, 6, 8'h5A);
    #1;
    n_tests++;
    if (in_rdy !== 5'b01000 || err !== 1'b0) begin
      n_fail++; $display("FAIL oob_rdy: rdy=%b err=%b expected 01000/0", in_rdy, err);
    end
    advance();
    clear_in();
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (err !== 1'b1 || out_vld !== '0) begin
        n_fail++; $display("FAIL oob_sticky[%0d]: err=%b vld=%b expected 1/0", c, err, out_vld);
      end
      advance();
    end
    do_reset();
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL oob_clear: err=%b expected 0", err); end
  endtask

  task automatic test_parallel();
    do_reset();
    for (int i = 0; i < N; i++) set_in(i, 1'b1, (i + 1) % N, 8'(i));
    #1;
    n_tests++;
    if (in_rdy !== 5'b11111) begin n_fail++; $display("FAIL par_rdy: got %b expected 11111", in_rdy); end
    advance();
    clear_in();
    n_tests++;
    if (out_vld !== 5'b11111) begin n_fail++; $display("FAIL par_vld: got %b expected 11111", out_vld); end
    for (int o = 0; o < N; o++) begin
      n_tests++;
      if (dout_of(o) !== 8'((o + N - 1) % N)) begin
        n_fail++; $display("FAIL par_data[%0d]: got %h expected %h", o, dout_of(o), 8'((o + N - 1) % N));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < N; i++) begin
        set_in(i, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4)),
               8'($urandom));
      end
      out_rdy = N'($urandom);
      #1;
      model_comb();
      n_tests++;
      if (in_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy[%0d]: got %b expected %b", c, in_rdy, exp_rdy); end
      @(posedge clk);
      model_edge();
      #1;
      n_tests++;
      if (out_vld !== m_vld_vec() || err !== m_err) begin
        n_fail++; $display("FAIL rand_state[%0d]: vld=%b err=%b expected %b/%b", c, out_vld, err, m_vld_vec(), m_err);
      end
      for (int o = 0; o < N; o++) begin
        n_tests++;
        if (dout_of(o) !== m_data[o]) begin
          n_fail++; $display("FAIL rand_data[%0d][%0d]: got %h expected %h", c, o, dout_of(o), m_data[o]);
        end
      end
    end
    rst_n = 1'b1; clear_in();
  endtask

  initial begin
    rst_n = 1'b0; out_rdy = '1; clear_in();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_invalid_sel();
    test_parallel();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

endmodule
